// File: rtl/snd_wr_sched.sv
// Sound-chip write scheduler: buffers ISA writes to OPL2 / SAA1099 #1 / #2 and
// replays them on a shared chip port with a per-target recovery gap after each.
module snd_wr_sched #(
  parameter int DEPTH        = 8,
  parameter int WR_PULSE     = 2,
  parameter int OPL_ADDR_GAP = 48,
  parameter int OPL_DATA_GAP = 280,
  parameter int SAA_GAP      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_wr,
  input  logic [1:0] io_sel,
  input  logic       io_a0,
  input  logic [7:0] io_d,
  output logic       bus_rdy,
  output logic       opl_cs_n,
  output logic       saa1_cs_n,
  output logic       saa2_cs_n,
  output logic       chip_a0,
  output logic [7:0] chip_d,
  output logic       chip_wr_n,
  output logic       busy,
  output logic       overflow
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int GMAX1 = (OPL_DATA_GAP > OPL_ADDR_GAP) ? OPL_DATA_GAP : OPL_ADDR_GAP;
  localparam int GMAX2 = (GMAX1 > SAA_GAP) ? GMAX1 : SAA_GAP;
  localparam int TMAX  = (GMAX2 > WR_PULSE) ? GMAX2 : WR_PULSE;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [CNTW-1:0] FULL_C     = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] RDY_C      = CNTW'(DEPTH - 1);
  localparam logic [TW-1:0]   PULSE_C    = TW'(WR_PULSE - 1);
  localparam logic [TW-1:0]   ADDR_GAP_C = TW'(OPL_ADDR_GAP);
  localparam logic [TW-1:0]   DATA_GAP_C = TW'(OPL_DATA_GAP);
  localparam logic [TW-1:0]   SAA_GAP_C  = TW'(SAA_GAP);
  localparam logic [TW-1:0]   ONE_C      = TW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

  // Entry layout: {sel[1:0], a0, d[7:0]}
  logic [10:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg, count_next;
  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [1:0]      sel_reg, sel_next;
  logic            a0_reg;
  logic [7:0]      d_reg;
  logic            bus_rdy_reg, overflow_reg, wr_n_reg;
  logic [2:0]      cs_n_reg;
  logic            push_req, push, pop, cs_on_next;
  logic [TW-1:0]   gap_len;

  assign push_req = io_wr && (io_sel != 2'd3);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = push_req && ((count_reg != FULL_C) || pop);
  assign count_next = count_reg + {{(CNTW-1){1'b0}}, push} - {{(CNTW-1){1'b0}}, pop};

  always_comb begin
    gap_len = SAA_GAP_C;
    if (sel_reg == 2'd0) begin
      gap_len = a0_reg ? DATA_GAP_C : ADDR_GAP_C;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = STROBE;
        timer_next = PULSE_C;
      end
      STROBE: begin
        if (timer_reg == '0) begin
          state_next = HOLD;
        end else begin
          timer_next = timer_reg - ONE_C;
        end
      end
      HOLD: begin
        timer_next = gap_len;
        state_next = (gap_len == '0) ? IDLE : GAP;
      end
      GAP: begin
        timer_next = timer_reg - ONE_C;
        if (timer_reg <= ONE_C) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Chip selects are registered from the next state so they are glitch-free
  // and already valid in the SETUP cycle that follows a pop.
  assign cs_on_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
  assign sel_next   = pop ? mem[rd_ptr_reg][10:9] : sel_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {io_sel, io_a0, io_d};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      sel_reg      <= 2'd0;
      a0_reg       <= 1'b0;
      d_reg        <= 8'd0;
      bus_rdy_reg  <= 1'b1;
      overflow_reg <= 1'b0;
      wr_n_reg     <= 1'b1;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg                 <= rd_ptr_reg + PW'(1);
        {sel_reg, a0_reg, d_reg}   <= mem[rd_ptr_reg];
      end
      // One slot of slack covers the ISA-side synchroniser latency.
      bus_rdy_reg <= (count_next < RDY_C);
      if (push_req && !push) begin
        overflow_reg <= 1'b1;
      end
      wr_n_reg <= (state_next != STROBE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cs
      logic cs_n_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          cs_n_q <= 1'b1;
        end else begin
          cs_n_q <= !(cs_on_next && (sel_next == 2'(gi)));
        end
      end
      assign cs_n_reg[gi] = cs_n_q;
    end
  endgenerate

  assign opl_cs_n  = cs_n_reg[0];
  assign saa1_cs_n = cs_n_reg[1];
  assign saa2_cs_n = cs_n_reg[2];
  assign chip_a0   = a0_reg;
  assign chip_d    = d_reg;
  assign chip_wr_n = wr_n_reg;
  assign bus_rdy   = bus_rdy_reg;
  assign overflow  = overflow_reg;
  assign busy      = (count_reg != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_snd_wr_sched.sv
// Bench for snd_wr_sched: directed and random writes checked every cycle against
// a queue-plus-timeline model of the scheduler.
module tb_snd_wr_sched;
  localparam int DEPTH    = 8;
  localparam int WR_PULSE = 2;
  localparam int ADDR_GAP = 48;
  localparam int DATA_GAP = 280;
  localparam int SAA_GAP  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_wr = 1'b0;
  logic [1:0] io_sel = 2'd0;
  logic       io_a0 = 1'b0;
  logic [7:0] io_d = 8'd0;
  logic       bus_rdy, opl_cs_n, saa1_cs_n, saa2_cs_n, chip_a0, chip_wr_n, busy, overflow;
  logic [7:0] chip_d;

  snd_wr_sched #(
    .DEPTH(DEPTH), .WR_PULSE(WR_PULSE), .OPL_ADDR_GAP(ADDR_GAP),
    .OPL_DATA_GAP(DATA_GAP), .SAA_GAP(SAA_GAP)
  ) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_sel(io_sel), .io_a0(io_a0), .io_d(io_d),
    .bus_rdy(bus_rdy), .opl_cs_n(opl_cs_n), .saa1_cs_n(saa1_cs_n), .saa2_cs_n(saa2_cs_n),
    .chip_a0(chip_a0), .chip_d(chip_d), .chip_wr_n(chip_wr_n), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       a0;
    logic [7:0] d;
  } ent_t;

  // Model: pending queue plus the setup cycle and gap of the last popped write.
  ent_t q[$];
  bit   has_tx = 0;
  int   tx_s = 0;
  int   tx_gap = 0;
  ent_t tx = '0;
  bit   m_ovf = 0;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int falls[$];
  bit prev_wr_n = 1;
  bit prev_busy = 0;
  int busy_fall = -1;
  bit both_low = 0;

  function automatic int gap_of(ent_t e);
    if (e.sel == 2'd0) return e.a0 ? DATA_GAP : ADDR_GAP;
    return SAA_GAP;
  endfunction

  function automatic bit m_idle(int t);
    return !has_tx || (t >= tx_s + 2 + WR_PULSE + tx_gap);
  endfunction

  function automatic int lf(int k);
    if (falls.size() > k) return falls[falls.size() - 1 - k];
    return -1000;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit act, wrl;
    act = has_tx && (cyc >= tx_s) && (cyc <= tx_s + WR_PULSE + 1);
    wrl = has_tx && (cyc >= tx_s + 1) && (cyc <= tx_s + WR_PULSE);
    check1("bus_rdy", bus_rdy, q.size() < DEPTH - 1);
    check1("opl_cs_n", opl_cs_n, !(act && tx.sel == 2'd0));
    check1("saa1_cs_n", saa1_cs_n, !(act && tx.sel == 2'd1));
    check1("saa2_cs_n", saa2_cs_n, !(act && tx.sel == 2'd2));
    check1("chip_wr_n", chip_wr_n, !wrl);
    check1("chip_a0", chip_a0, tx.a0);
    check8("chip_d", chip_d, tx.d);
    check1("busy", busy, (q.size() > 0) || !m_idle(cyc));
    check1("overflow", overflow, m_ovf);
  endtask

  task automatic m_step(input bit rst, input bit wr, input logic [1:0] sel,
                        input logic a0, input logic [7:0] d);
    int n;
    bit pop;
    if (rst) begin
      q.delete();
      has_tx = 0;
      tx = '0;
      tx_s = 0;
      tx_gap = 0;
      m_ovf = 0;
      return;
    end
    n = q.size();
    pop = m_idle(cyc) && (n > 0);
    if (pop) begin
      tx = q.pop_front();
      has_tx = 1;
      tx_s = cyc + 1;
      tx_gap = gap_of(tx);
    end
    if (wr && sel != 2'd3) begin
      if (n < DEPTH || pop) q.push_back({sel, a0, d});
      else m_ovf = 1;
    end
  endtask

  // One clock: check this cycle's outputs, then drive inputs sampled at the next edge.
  task automatic step(input bit rst, input bit wr, input logic [1:0] sel,
                      input logic a0, input logic [7:0] d);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (prev_wr_n && !chip_wr_n) falls.push_back(cyc);
    if (prev_busy && !busy) busy_fall = cyc;
    if ((!opl_cs_n + !saa1_cs_n + !saa2_cs_n) > 1) both_low = 1;
    prev_wr_n = chip_wr_n;
    prev_busy = busy;
    reset = rst;
    io_wr = wr;
    io_sel = sel;
    io_a0 = a0;
    io_d = d;
    m_step(rst, wr, sel, a0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 1'b0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic a0, input logic [7:0] d);
    step(0, 1, sel, a0, d);
  endtask

  task automatic wait_quiet(input int bound, input string tag);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step(0, 0, 2'd0, 1'b0, 8'd0);
      if (!busy && q.size() == 0 && m_idle(cyc)) done = 1;
    end
    check1(tag, done, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t_n;
    bit seen;
    logic [1:0] rs;

    // Reset
    step(1, 0, 2'd0, 1'b0, 8'd0);
    step(0, 0, 2'd0, 1'b0, 8'd0);
    check1("rst_bus_rdy", bus_rdy, 1'b1);
    check1("rst_wr_n", chip_wr_n, 1'b1);
    check1("rst_busy", busy, 1'b0);
    idle(3);

    // Single OPL address write
    wr(2'd0, 1'b0, 8'h20);
    t_n = cyc;
    wait_quiet(200, "t1_quiet");
    checkint("t1_fall", lf(0), t_n + 3);
    checkint("t1_busy_fall", busy_fall, t_n + 4 + WR_PULSE + ADDR_GAP);

    // OPL address/data pair
    wr(2'd0, 1'b0, 8'hB0);
    t_n = cyc;
    wr(2'd0, 1'b1, 8'h31);
    wait_quiet(800, "t2_quiet");
    checkint("t2_first_fall", lf(1), t_n + 3);
    checkint("t2_pair_gap", lf(0) - (lf(1) + WR_PULSE), ADDR_GAP + 3);
    checkint("t2_busy_end", busy_fall - (lf(0) + WR_PULSE), DATA_GAP + 1);

    // SAA interleave
    wr(2'd1, 1'b0, 8'h1C);
    wr(2'd2, 1'b0, 8'h02);
    wait_quiet(100, "t3_quiet");
    checkint("t3_saa_gap", lf(0) - (lf(1) + WR_PULSE), SAA_GAP + 3);
    check1("t3_cs_exclusive", both_low, 1'b0);

    // Full FIFO behind a long OPL data gap
    n0 = falls.size();
    wr(2'd0, 1'b1, 8'h55);
    for (int k = 0; k < 10; k++) begin
      wr(2'd0, 1'b0, 8'(8'h10 + k));
      idle(1);
      check1("t4_bus_rdy", bus_rdy, k < 6);
      check1("t4_overflow", overflow, k >= 8);
    end
    wait_quiet(2000, "t4_quiet");
    checkint("t4_emerged", falls.size() - n0, 9);
    check1("t4_overflow_sticky", overflow, 1'b1);

    // Reset in the middle of a strobe
    wr(2'd2, 1'b1, 8'hA5);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      if (chip_wr_n === 1'b0) seen = 1;
    end
    check1("t5_strobe_seen", seen, 1'b1);
    step(1, 0, 2'd0, 1'b0, 8'd0);
    step(0, 0, 2'd0, 1'b0, 8'd0);
    check1("t5_wr_n", chip_wr_n, 1'b1);
    check1("t5_saa2_cs_n", saa2_cs_n, 1'b1);
    check1("t5_busy", busy, 1'b0);
    check1("t5_overflow", overflow, 1'b0);
    n0 = falls.size();
    idle(60);
    checkint("t5_no_strobe", falls.size(), n0);

    // Unmapped target is ignored
    for (int i = 0; i < 4; i++) begin
      wr(2'd3, 1'($urandom), 8'($urandom));
      idle(1);
    end
    idle(10);
    checkint("t6_no_strobe", falls.size(), n0);
    check1("t6_busy", busy, 1'b0);

    // Random mix of all targets, with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) step(1, 0, 2'd0, 1'b0, 8'd0);
      else if ($urandom_range(0, 3) == 0) wr(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
      else idle(1);
    end
    wait_quiet(6000, "t7_drain");

    // Dense short-gap traffic: FIFO runs full with pushes coinciding with pops
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rs = 2'($urandom_range(0, 3));
        wr(rs, (rs == 2'd0) ? 1'b0 : 1'($urandom), 8'($urandom));
      end else begin
        idle(1);
      end
    end
    wait_quiet(3000, "t8_drain");
    check1("t8_cs_exclusive", both_low, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
